pokecoin_ctrl: RTL and testbench

- Coin game-logic stage directly upstream of the coin sprite renderer; drives its pos_x, pos_y and enable inputs.
- Spawns one 32x32 coin at a pseudo-random on-screen position, checks overlap with Pikachu's 32x32 box once per frame, counts collected coins, and hides/respawns the coin after collection or expiry.
- All position and enable updates happen only on frame_tick (start of vertical blank), so a coin never tears mid-frame.

---
 rtl/pokecoin_ctrl.sv | 144 ++++++++++++++
 tb/tb_pokecoin_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pokecoin_ctrl.sv
// Coin game logic: spawns a coin from an LFSR, scores overlaps with the player,
// and hides/respawns it. All visible updates happen on frame_tick only.
module pokecoin_ctrl #(
  parameter int          X_MIN           = 48,
  parameter int          Y_MIN           = 160,
  parameter int          LIFETIME_FRAMES = 300,
  parameter int          RESPAWN_FRAMES  = 60,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start,
  input  logic [9:0] player_x,
  input  logic [9:0] player_y,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic       coin_en,
  output logic [7:0] score,
  output logic       collect_pulse
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SPAWN,
    ACTIVE,
    COOLDOWN
  } state_t;

  localparam logic [8:0] LIFE_LAST = 9'(LIFETIME_FRAMES - 1);
  localparam logic [8:0] RESP_LAST = 9'(RESPAWN_FRAMES - 1);

  state_t      state_q, state_d;
  logic [15:0] lfsr_q;
  logic        lfsr_fb;
  logic [8:0]  cnt_q, cnt_d;
  logic [9:0]  pos_x_q, pos_x_d;
  logic [9:0]  pos_y_q, pos_y_d;
  logic        en_q, en_d;
  logic [7:0]  score_q, score_d;
  logic        pulse_q, pulse_d;

  logic [9:0]         spawn_x, spawn_y;
  logic signed [10:0] dx, dy;
  logic               hit;
  logic [7:0]         score_inc;

  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  assign spawn_x = 10'(X_MIN) + {1'b0, lfsr_q[8:0]};
  assign spawn_y = 10'(Y_MIN) + {2'b00, lfsr_q[15:10], 2'b00};

  // Zero-extend before subtracting so the difference never wraps.
  assign dx  = $signed({1'b0, player_x}) - $signed({1'b0, pos_x_q});
  assign dy  = $signed({1'b0, player_y}) - $signed({1'b0, pos_y_q});
  assign hit = (dx > -11'sd32) && (dx < 11'sd32) &&
               (dy > -11'sd32) && (dy < 11'sd32);

  assign score_inc = (score_q == 8'hFF) ? score_q : score_q + 8'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    en_d    = en_q;
    score_d = score_q;
    pulse_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = WAIT_SPAWN;
      end
      WAIT_SPAWN: begin
        if (frame_tick) begin
          pos_x_d = spawn_x;
          pos_y_d = spawn_y;
          en_d    = 1'b1;
          cnt_d   = '0;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (frame_tick) begin
          if (hit) begin
            score_d = score_inc;
            pulse_d = 1'b1;
            en_d    = 1'b0;
            cnt_d   = '0;
            state_d = COOLDOWN;
          end else if (cnt_q == LIFE_LAST) begin
            en_d    = 1'b0;
            cnt_d   = '0;
            state_d = COOLDOWN;
          end else begin
            cnt_d = cnt_q + 9'd1;
          end
        end
      end
      COOLDOWN: begin
        if (frame_tick) begin
          if (cnt_q == RESP_LAST) begin
            pos_x_d = spawn_x;
            pos_y_d = spawn_y;
            en_d    = 1'b1;
            cnt_d   = '0;
            state_d = ACTIVE;
          end else begin
            cnt_d = cnt_q + 9'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lfsr_q  <= LFSR_SEED;
      cnt_q   <= '0;
      pos_x_q <= '0;
      pos_y_q <= '0;
      en_q    <= 1'b0;
      score_q <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= {lfsr_q[14:0], lfsr_fb};
      cnt_q   <= cnt_d;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      en_q    <= en_d;
      score_q <= score_d;
      pulse_q <= pulse_d;
    end
  end

  assign pos_x         = pos_x_q;
  assign pos_y         = pos_y_q;
  assign coin_en       = en_q;
  assign score         = score_q;
  assign collect_pulse = pulse_q;

endmodule

// File: tb/tb_pokecoin_ctrl.sv
// Scoreboard bench for pokecoin_ctrl: a reference model predicts every
// cycle's outputs into a queue; a negedge monitor pops and compares.
module tb_pokecoin_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_tick;
  logic       start;
  logic [9:0] player_x;
  logic [9:0] player_y;
  logic [9:0] pos_x;
  logic [9:0] pos_y;
  logic       coin_en;
  logic [7:0] score;
  logic       collect_pulse;

  always #5 clk = ~clk;

  pokecoin_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .frame_tick    (frame_tick),
    .start         (start),
    .player_x      (player_x),
    .player_y      (player_y),
    .pos_x         (pos_x),
    .pos_y         (pos_y),
    .coin_en       (coin_en),
    .score         (score),
    .collect_pulse (collect_pulse)
  );

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       en;
    logic [7:0] sc;
    logic       p;
  } exp_t;

  exp_t q[$];
  int   passes = 0;
  int   fails  = 0;

  logic [15:0] m_lfsr;
  bit          m_play, m_wait, m_shown, m_pulse;
  int          m_left, m_x, m_y, m_score;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], ^(v & 16'hB400)};
  endfunction

  function automatic bit overlaps(input int px, input int py,
                                  input int cx, input int cy);
    int ax, ay;
    ax = px - cx;
    ay = py - cy;
    if (ax < 0) ax = -ax;
    if (ay < 0) ay = -ay;
    return (ax < 32) && (ay < 32);
  endfunction

  task automatic m_spawn();
    m_x     = 48 + int'(m_lfsr[8:0]);
    m_y     = 160 + 4 * int'(m_lfsr[15:10]);
    m_shown = 1;
    m_left  = 300;
  endtask

  // Model: countdowns of remaining visible/hidden frames.
  always @(posedge clk) begin
    exp_t e;
    m_pulse = 0;
    if (rst) begin
      m_lfsr  = 16'hACE1;
      m_play  = 0;
      m_wait  = 0;
      m_shown = 0;
      m_left  = 0;
      m_x     = 0;
      m_y     = 0;
      m_score = 0;
    end else begin
      if (!m_play) begin
        if (start) begin
          m_play = 1;
          m_wait = 1;
        end
      end else if (frame_tick) begin
        if (m_wait) begin
          m_wait = 0;
          m_spawn();
        end else if (m_shown) begin
          if (overlaps(int'(player_x), int'(player_y), m_x, m_y)) begin
            m_score = (m_score < 255) ? m_score + 1 : 255;
            m_pulse = 1;
            m_shown = 0;
            m_left  = 60;
          end else begin
            m_left--;
            if (m_left == 0) begin
              m_shown = 0;
              m_left  = 60;
            end
          end
        end else begin
          m_left--;
          if (m_left == 0) m_spawn();
        end
      end
      m_lfsr = lfsr_step(m_lfsr);
    end
    e.x  = 10'(m_x);
    e.y  = 10'(m_y);
    e.en = m_shown;
    e.sc = 8'(m_score);
    e.p  = m_pulse;
    q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e, a;
    if (q.size() > 0) begin
      e = q.pop_front();
      a = '{x: pos_x, y: pos_y, en: coin_en, sc: score, p: collect_pulse};
      if (a === e) begin
        passes++;
      end else begin
        fails++;
        $display("FAIL outputs t=%0t: got x=%0d y=%0d en=%b sc=%0d p=%b, need x=%0d y=%0d en=%b sc=%0d p=%b",
                 $time, a.x, a.y, a.en, a.sc, a.p, e.x, e.y, e.en, e.sc, e.p);
      end
    end
  end

  int gap_max = 3;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    cyc(1);
    frame_tick = 1'b0;
    cyc($urandom_range(1, gap_max));
  endtask

  task automatic far();
    player_x = '0;
    player_y = '0;
  endtask

  task automatic at(input int dx, input int dy);
    player_x = 10'(m_x + dx);
    player_y = 10'(m_y + dy);
  endtask

  task automatic await_shown(input int lim);
    int n = 0;
    far();
    while (!m_shown && n < lim) begin
      tick();
      n++;
    end
    if (!m_shown) begin
      fails++;
      $display("FAIL respawn_wait: coin_en=%b after %0d ticks, need 1", coin_en, n);
    end
  endtask

  int offs[10][2] = '{
    '{31, 0}, '{32, 0}, '{-31, 0}, '{-32, 0},
    '{0, 31}, '{0, 32}, '{0, -31}, '{0, -32},
    '{31, 31}, '{-32, -31}
  };

  initial begin
    int n;
    rst        = 1'b1;
    start      = 1'b0;
    frame_tick = 1'b0;
    far();
    cyc(2);
    rst = 1'b0;
    cyc(3);

    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(4);
    tick();

    foreach (offs[i]) begin
      await_shown(100);
      at(offs[i][0], offs[i][1]);
      tick();
      far();
    end

    await_shown(100);
    n = 0;
    while (m_shown && n < 400) begin
      tick();
      n++;
    end
    await_shown(100);

    await_shown(100);
    n = 0;
    while (m_shown && m_left > 1 && n < 400) begin
      tick();
      n++;
    end
    at(31, -31);
    tick();
    far();

    repeat (300) begin
      int r;
      r = int'($urandom_range(0, 3));
      if (r == 0) far();
      else if (r == 3) begin
        player_x = 10'($urandom_range(0, 639));
        player_y = 10'($urandom_range(0, 479));
      end else begin
        at(int'($urandom_range(0, 80)) - 40, int'($urandom_range(0, 80)) - 40);
      end
      start = 1'($urandom_range(0, 1));
      tick();
      start = 1'b0;
    end

    gap_max = 1;
    repeat (256) begin
      await_shown(100);
      at(5, -7);
      tick();
      far();
    end
    gap_max = 3;

    await_shown(100);
    at(0, 0);
    tick();
    far();
    repeat (30) tick();
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    repeat (70) tick();
    cyc(3);

    $display("%0d/%0d checks passed", passes, passes + fails);
    $finish;
  end

endmodule
